// File: rtl/rfa_rr_request_stage.sv
// Round-robin request-holding stage for the register-file arbiter.
// Holds request pulses, rotates them for the encoder, and registers the grant.
module rfa_rr_request_stage #(
    parameter logic [3:0] PTR_RESET = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req,
    input  logic        rf_busy,
    output logic [15:0] enc_in,
    output logic        enc_en,
    input  logic [3:0]  enc_out,
    output logic        grant_valid,
    output logic [3:0]  grant_id,
    output logic [15:0] grant_onehot,
    output logic [15:0] pending
);

    logic [15:0] pending_q, pending_d;
    logic [3:0]  ptr_q, ptr_d;
    logic        gv_q, gv_d;
    logic [3:0]  gid_q, gid_d;
    logic [15:0] goh_q, goh_d;
    logic [15:0] clr_mask;
    logic [3:0]  sel;

    // Rotate pending so the priority holder sits at bit 0
    always_comb begin
        enc_in = 16'({pending_q, pending_q} >> ptr_q);
        enc_en = (|pending_q) & ~rf_busy;
        sel    = enc_out + ptr_q;
    end

    // Grant formation; encoder result only used when enabled
    always_comb begin
        clr_mask = '0;
        ptr_d    = ptr_q;
        gv_d     = 1'b0;
        gid_d    = '0;
        goh_d    = '0;
        if (enc_en) begin
            clr_mask = 16'b1 << sel;
            ptr_d    = sel + 4'd1;
            gv_d     = 1'b1;
            gid_d    = sel;
            goh_d    = 16'b1 << sel;
        end
        pending_d = (pending_q & ~clr_mask) | req;
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= '0;
            ptr_q     <= PTR_RESET;
            gv_q      <= 1'b0;
            gid_q     <= '0;
            goh_q     <= '0;
        end else begin
            pending_q <= pending_d;
            ptr_q     <= ptr_d;
            gv_q      <= gv_d;
            gid_q     <= gid_d;
            goh_q     <= goh_d;
        end
    end

    assign grant_valid  = gv_q;
    assign grant_id     = gid_q;
    assign grant_onehot = goh_q;
    assign pending      = pending_q;

endmodule

// File: tb/tb_rfa_rr_request_stage.sv
// Bench for rfa_rr_request_stage: directed literal scenarios plus
// randomized traffic checked every cycle against a fair-arbiter model.
module tb_rfa_rr_request_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req = '0;
    logic        rf_busy = 1'b0;
    logic [15:0] enc_in;
    logic        enc_en;
    logic [3:0]  enc_out;
    logic        grant_valid;
    logic [3:0]  grant_id;
    logic [15:0] grant_onehot;
    logic [15:0] pending;

    int errs = 0;
    int checks = 0;
    bit chk_on = 1'b0;
    logic [3:0] junk = 4'hA;

    rfa_rr_request_stage #(.PTR_RESET(4'd0)) dut (
        .clk(clk), .rst(rst), .req(req), .rf_busy(rf_busy),
        .enc_in(enc_in), .enc_en(enc_en), .enc_out(enc_out),
        .grant_valid(grant_valid), .grant_id(grant_id),
        .grant_onehot(grant_onehot), .pending(pending)
    );

    always #5 clk = ~clk;

    // External priority encoder; garbage when nothing is set
    always_comb begin
        enc_out = junk;
        for (int i = 15; i >= 0; i--)
            if (enc_in[i]) enc_out = 4'(i);
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: pending set, pointer, last grant
    logic [15:0] m_pend = '0;
    int          m_ptr = 0;
    bit          m_gv = 0;
    int          m_gid = 0;

    always @(posedge clk) begin
        logic [15:0] r;
        logic [15:0] rot;
        bit b, x;
        r = req; b = rf_busy; x = rst;
        if (x) begin
            m_pend = '0; m_ptr = 0; m_gv = 0; m_gid = 0;
        end else begin
            m_gv = 0; m_gid = 0;
            if (m_pend != 0 && !b) begin
                for (int j = 0; j < 16; j++) begin
                    int k;
                    k = (m_ptr + j) % 16;
                    if (!m_gv && m_pend[k]) begin
                        m_gv = 1; m_gid = k;
                    end
                end
                m_pend[m_gid] = 1'b0;
                m_ptr = (m_gid + 1) % 16;
            end
            m_pend = m_pend | r;
        end
        #1;
        if (chk_on) begin
            rot = '0;
            for (int i = 0; i < 16; i++) rot[i] = m_pend[(i + m_ptr) % 16];
            chk("m_valid", 32'(grant_valid), 32'(m_gv));
            chk("m_id", 32'(grant_id), 32'(m_gid));
            chk("m_onehot", 32'(grant_onehot),
                m_gv ? (32'h1 << m_gid) : 32'h0);
            chk("m_pending", 32'(pending), 32'(m_pend));
            chk("m_enc_in", 32'(enc_in), 32'(rot));
            chk("m_enc_en", 32'(enc_en),
                32'((m_pend != 0) && !rf_busy));
        end
    end

    task automatic step(input logic [15:0] r, input logic b, input logic x);
        @(negedge clk);
        req = r; rf_busy = b; rst = x;
        junk = 4'($urandom);
        @(posedge clk);
        #2;
    endtask

    initial begin
        step(16'h0, 0, 1);
        step(16'h0, 0, 1);
        chk_on = 1'b1;
        chk("rst_valid", 32'(grant_valid), 32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        chk("rst_onehot", 32'(grant_onehot), 32'h0);
        chk("rst_id", 32'(grant_id), 32'h0);

        // 1: single request
        step(16'h0001, 0, 0);
        chk("t1_pend", 32'(pending), 32'h0001);
        chk("t1_nogv", 32'(grant_valid), 32'h0);
        step(16'h0, 0, 0);
        chk("t1_gv", 32'(grant_valid), 32'h1);
        chk("t1_id", 32'(grant_id), 32'h0);
        chk("t1_oh", 32'(grant_onehot), 32'h0001);
        chk("t1_pend0", 32'(pending), 32'h0);

        // 2: all pending, round robin sweep
        step(16'h0, 0, 1);
        step(16'hFFFF, 0, 0);
        for (int i = 0; i < 17; i++) begin
            step(16'hFFFF, 0, 0);
            chk("t2_gv", 32'(grant_valid), 32'h1);
            chk("t2_id", 32'(grant_id), 32'(i % 16));
        end

        // 3: wrap from ptr 14
        step(16'h0, 0, 1);
        step(16'h2000, 0, 0);
        step(16'h4003, 0, 0);
        chk("t3_id13", 32'(grant_id), 32'd13);
        chk("t3_pend", 32'(pending), 32'h4003);
        step(16'h0, 0, 0);
        chk("t3_id14", 32'(grant_id), 32'd14);
        step(16'h0, 0, 0);
        chk("t3_id0", 32'(grant_id), 32'd0);
        step(16'h0007, 0, 0);
        chk("t3_id1", 32'(grant_id), 32'd1);
        step(16'h0, 0, 0);
        chk("t3_ptr2", 32'(grant_id), 32'd2);

        // 4: busy holds
        step(16'h0, 0, 1);
        step(16'h0100, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(16'h0, 1, 0);
            chk("t4_gv", 32'(grant_valid), 32'h0);
            chk("t4_pend", 32'(pending), 32'h0100);
        end
        step(16'h0, 0, 0);
        chk("t4_gv1", 32'(grant_valid), 32'h1);
        chk("t4_id", 32'(grant_id), 32'd8);

        // 5: set wins over clear
        step(16'h0, 0, 1);
        step(16'h0010, 0, 0);
        step(16'h0020, 0, 0);
        chk("t5_id4", 32'(grant_id), 32'd4);
        step(16'h0020, 0, 0);
        chk("t5_id5", 32'(grant_id), 32'd5);
        chk("t5_pend", 32'(pending), 32'h0020);
        step(16'h0, 0, 0);
        chk("t5_id5b", 32'(grant_id), 32'd5);
        chk("t5_pend0", 32'(pending), 32'h0);

        // 6: reset mid-operation
        step(16'h0, 0, 1);
        step(16'h00F0, 0, 0);
        step(16'h0, 0, 1);
        chk("t6_gv", 32'(grant_valid), 32'h0);
        chk("t6_pend", 32'(pending), 32'h0);
        step(16'h0, 0, 0);
        chk("t6_gv2", 32'(grant_valid), 32'h0);
        step(16'h0003, 0, 0);
        chk("t6_gv3", 32'(grant_valid), 32'h0);
        step(16'h0, 0, 0);
        chk("t6_id", 32'(grant_id), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            logic [15:0] r;
            int mode;
            mode = $urandom_range(0, 9);
            if (mode < 5) r = 16'(1 << $urandom_range(0, 15)) & 16'($urandom);
            else if (mode < 8) r = 16'($urandom) & 16'($urandom);
            else if (mode == 8) r = 16'hFFFF;
            else r = '0;
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/rfa_rr_request_stage.md
Name: rfa_rr_request_stage

Overview:
- Round-robin request-holding stage for the register-file arbiter. Sits directly upstream of the 16-to-4 priority encoder.
- Latches per-source request pulses into a pending vector and rotates that vector so the current priority holder lands on bit 0. It drives the encoder with the rotated vector and an enable, takes the 4-bit encoder result back, and un-rotates it into a registered grant.
- Advances the round-robin pointer past each granted source so all 16 sources get fair access to the register-file port.

Parameters:
- PTR_RESET, 4'd0, value loaded into the round-robin pointer on reset.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  16  per-source request pulse; bit i high for one cycle sets pending[i].
- rf_busy  input  1  register-file port unavailable this cycle; no grant issued while high.
- enc_in  output  16  rotated pending vector driven to the priority encoder (combinational).
- enc_en  output  1  encoder enable (combinational).
- enc_out  input  4  encoder result: lowest set index of enc_in.
- grant_valid  output  1  registered; one grant issued this cycle.
- grant_id  output  4  registered; index of granted source.
- grant_onehot  output  16  registered; one-hot of grant_id, all zero when grant_valid is 0.
- pending  output  16  registered pending-request vector.

Behaviour:
- Synchronous reset, active-high, on clk:
  - pending=0, ptr=PTR_RESET.
  - grant_valid=0, grant_id=0, grant_onehot=0.
  - Reset asserted mid-operation discards all pending requests and any grant being formed; the first cycle after reset deasserts shows grant_valid=0.
- Rotation: enc_in[i] = pending[(i+ptr) mod 16] for i=0..15, with 4-bit wrap on the index sum.
- enc_en = (|pending) & !rf_busy. When enc_en=0, enc_out is ignored; X from the encoder must never reach any register.
- Selected index: sel = (enc_out + ptr) mod 16, 4-bit add with the carry discarded.
- Grant cycle (enc_en=1), registered at the clock edge:
  - grant_valid<=1, grant_id<=sel, grant_onehot<=(16'b1<<sel).
  - pending[sel]<=0, unless req[sel] is also high this cycle; set wins, so pending[sel] stays 1.
  - ptr<=sel+1 mod 16 (sel=15 wraps ptr to 0).
- Non-grant cycle: grant_valid<=0, grant_id<=0, grant_onehot<=0, ptr holds.
- Pending update every cycle: pending <= (pending & ~clear_mask) | req. clear_mask is the one-hot of sel on a grant cycle, else 0.
  - A req bit already pending is absorbed; there is no counting.
- Latency:
  - req high in cycle N -> pending visible in N+1 -> earliest grant_valid in N+2.
  - No bypass from req to grant.
- Throughput: at most one grant per cycle; back-to-back grants allowed while pending is non-zero and rf_busy is low.
- rf_busy high: pending and ptr hold apart from new req bits ORing in; grant_valid=0 the following cycle.
- Fairness: a source that has just been granted is the lowest priority next. With all 16 sources continuously pending and rf_busy=0, every source is granted once within any 16 consecutive grants.
- Empty pending: enc_en=0, no grant, ptr unchanged.
- Full pending (16'hFFFF): grant goes to source ptr.

Test Plan:
1. Reset, then req=16'h0001 in one cycle -> pending=16'h0001 next cycle; following cycle grant_valid=1, grant_id=0, grant_onehot=16'h0001; then pending=0 and ptr=1.
2. pending=16'hFFFF held (req=16'hFFFF every cycle), rf_busy=0, ptr=0 -> grant_id sequence 0,1,2,…,15,0 on consecutive cycles; grant_valid stays 1.
3. ptr=14, pending=16'h4003 (bits 0,1,14) -> grants in order 14, 0, 1; ptr after the last grant = 2.
4. pending=16'h0100, rf_busy=1 for 3 cycles -> grant_valid=0 throughout, pending unchanged; rf_busy drops -> grant_id=8 one cycle later.
5. pending=16'h0020 and ptr=5 granting this cycle while req=16'h0020 -> grant_id=5; pending stays 16'h0020; next grant is also 5, since it is the only pending bit.
6. pending=16'h00F0 with grant in flight, rst=1 for one cycle -> pending=0, grant_valid=0, ptr=PTR_RESET; no grant appears after rst deasserts until a new req arrives.
